cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Shares a single `cbus` memory port between several cache-side requesters (ICache, DCache, and later an uncached path). Each cache issues `cbus_req_t` transactions, single beats or bursts. The arbiter grants one requester at a time, forwards its request to the memory side, and returns the response only to that requester. The grant is held until the final beat completes. The block sits between the cache layer and the memory/AXI bridge in the core top.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters. Index 0 is the DCache and index 1 is the ICache.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low reset. Asserting it (0) forces all state to reset immediately.
- `ireqs`, input, `cbus_req_t [N_REQ]`: requests from the caches.
- `iresps`, output, `cbus_resp_t [N_REQ]`: per-requester responses.
- `oreq`, output, `cbus_req_t`: request to the memory side.
- `oresp`, input, `cbus_resp_t`: response from the memory side.

## Operation
- State machine with two states:
  - `IDLE`: no owner. `oreq` is all-zero and every `iresps[i]` is all-zero.
  - `BUSY`: owner index `sel` is registered. `oreq = ireqs[sel]` combinationally. `iresps[sel] = oresp`, and all other `iresps` are all-zero.
- `IDLE` → `BUSY`: taken when any `ireqs[i].valid` is set. The winner is chosen by the arbitration policy (see Configuration) and latched into `sel`.
- `BUSY` → `IDLE`: taken when `oresp.ready && oresp.last`. The owner is released on that clock edge.
- Requesters must hold `valid` and the request fields stable from assertion until they see `ready && last`.
- If the owner drops `valid` early, the arbiter stays in `BUSY` and forwards `valid = 0`. It does not release until `ready && last` arrives. No hidden abort is performed.
- Non-owner requests stay pending with no side effects. No request is ever lost.
- `sel` width is `$clog2(N_REQ)`, minimum 1 bit.
- Reset values:
  - state is `IDLE`, `sel` = 0, round-robin pointer = 0.
  - `oreq` and all `iresps` are zero (`valid` = 0, `ready` = 0, `last` = 0).
- Reset asserted mid-burst: return to `IDLE` asynchronously. The memory side is reset by the same signal.

## Timing
- Arbitration latency is 1 cycle:
  - `valid` first seen in `IDLE` at edge t.
  - `sel` and state update at edge t.
  - `oreq.valid` is visible in the cycle after t.
- The response path is purely combinational. The owner sees `ready`/`last`/`data` in the same cycle `oresp` presents them.
- `ready && last` in cycle u returns the block to `IDLE` after edge u. The next grant takes effect after edge u+1. Minimum gap between two transactions is therefore one `IDLE` cycle.
- Simultaneous requests in `IDLE`: exactly one winner per the policy. The losers are granted in later `IDLE` cycles.
- A new request arriving while in `BUSY` is ignored until `IDLE`.
- A single-beat transaction (`len` = 0) behaves like a 1-beat burst. It completes on its first `ready`, which arrives with `last` = 1.

## Configuration
- `CBUS_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A pointer `ptr` records the next index with highest priority.
  - The search starts at `ptr` and wraps modulo `N_REQ`.
  - On each grant of index k, `ptr` is set to `(k+1) mod N_REQ`. For `N_REQ` = 2, two always-valid requesters therefore alternate.
- Undefined: fixed priority, lowest index wins (DCache over ICache). No pointer register exists.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with `ireqs[0].valid` = 1. Require `oreq.valid` = 0 and all `iresps` = 0. Release `reset`; require `oreq.valid` = 1 one cycle later with `oreq.addr` = `ireqs[0].addr`.
- **Single owner burst:** ICache requests `addr` = 0x8000_0000, `len` = 3. Memory gives `ready` on 4 beats with `last` on beat 4. Require:
  - `iresps[1]` sees all 4 beats with matching `data`.
  - `iresps[0].ready` = 0 throughout.
  - state returns to `IDLE` after `last`.
- **Simultaneous request, policy without the macro:** both caches assert `valid` in the same cycle. Require:
  - DCache is granted first.
  - ICache is granted in the cycle after DCache's `last` + 1.
  - The ICache request still has its original address.
- **Round robin with the macro:** both caches are always valid, with single-beat transactions. Require grants to alternate 0,1,0,1 over 4 transactions.
- **Owner drop and late requester:** DCache deasserts `valid` mid-burst while ICache requests. Require:
  - the grant stays with DCache until `ready && last`.
  - ICache is granted only afterwards.
- **Asynchronous reset mid-burst:** assert `reset` = 0 between clock edges during beat 2. Require `oreq.valid` = 0 immediately, before the next edge, and state `IDLE`.

Source files
------------

// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//
// Shares one cbus memory port between N_REQ cache-side requesters
// (index 0 = DCache, index 1 = ICache). One requester owns the port from grant
// until the memory side returns ready && last. While it owns the port, its
// request is forwarded to the memory side and the memory response is routed
// back to it alone. Every other requester sees an all-zero response.
//
// Configuration macro:
//   CBUS_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration. The
//                                         rotating pointer starts at 0.
//                            undefined -> fixed priority. The lowest index
//                                         wins, and no pointer register exists.
//
// Parameters:
//   N_REQ   number of requesters (default 2)
//
// Ports:
//   clk     clock
//   reset   asynchronous active-low reset
//   ireqs   requests from the caches          (cbus_req_t  [N_REQ])
//   iresps  per-requester responses           (cbus_resp_t [N_REQ])
//   oreq    request to the memory side        (cbus_req_t)
//   oresp   response from the memory side     (cbus_resp_t)
// -----------------------------------------------------------------------------

package cbus_pkg;

  // One cache-bus request. Fields are held stable by the requester until it
  // observes ready && last.
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;     // beats minus one; 0 = single beat
    logic [1:0]  burst;
  } cbus_req_t;

  // One cache-bus response beat.
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [N_REQ],
  output cbus_resp_t iresps [N_REQ],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  sel_t             sel;
  logic [N_REQ-1:0] valid_vec;
  logic             any_valid;
  sel_t             winner;
  logic             done;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  sel_t ptr;
  sel_t ptr_next;
`endif

  // Fixed priority: the lowest set index wins.
  function automatic sel_t pick_fixed(input logic [N_REQ-1:0] v);
    sel_t w;
    w = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        w = sel_t'(i);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  // Round robin: scan upward from p and wrap modulo N_REQ. The first valid
  // index found wins.
  function automatic sel_t pick_rr(input logic [N_REQ-1:0] v, input sel_t p);
    sel_t w;
    logic found;
    int   idx;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && v[idx]) begin
        w     = sel_t'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction
`endif

  // Collect the request valids and pick a candidate winner for the IDLE state.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
    any_valid = |valid_vec;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
    winner = pick_rr(valid_vec, ptr);
    if (int'(winner) == N_REQ - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = winner + sel_t'(1);
    end
`else
    winner = pick_fixed(valid_vec);
`endif
  end

  // The transaction ends only on the final accepted beat. A dropped valid from
  // the owner does not end it.
  assign done = oresp.ready & oresp.last;

  // Grant FSM: latch the owner on entry to BUSY and release it on ready && last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state <= BUSY;
            sel   <= winner;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            ptr   <= ptr_next;
`endif
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
          end else begin
            state <= BUSY;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

  // Forward the owner's request and route the memory response back to it.
  // Outputs are gated by the registered state, so a reset takes effect on
  // them without waiting for a clock edge.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < N_REQ; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (sel == sel_t'(i)) begin
          oreq      = ireqs[i];
          iresps[i] = oresp;
        end else begin
          iresps[i] = '0;
        end
      end
    end else begin
      oreq = '0;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cbus_arbiter
//
// Directed bench for cbus_arbiter with N_REQ = 2. Inputs change 1 ns after
// each rising edge. Outputs are sampled 1 ns after that, away from the edge.
// -----------------------------------------------------------------------------

module tb_cbus_arbiter;
  import cbus_pkg::*;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs  [2];
  cbus_resp_t iresps [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int total;
  int bad;

  cbus_arbiter #(.N_REQ(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [31:0] a, input logic [7:0] l);
    ireqs[idx]       = '0;
    ireqs[idx].valid = v;
    ireqs[idx].addr  = a;
    ireqs[idx].len   = l;
    ireqs[idx].size  = 3'd3;
  endtask

  task automatic set_resp(input logic r, input logic l, input logic [63:0] d);
    oresp.ready = r;
    oresp.last  = l;
    oresp.data  = d;
  endtask

  logic [31:0] exp_addr;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp    = '0;

    // ---------------- reset held with a pending DCache request ----------------
    set_req(0, 1'b1, 32'h1000_0040, 8'd0);
    set_resp(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_oreq_valid", {63'd0, oreq.valid}, 64'd0);
      check("rst_iresp0",     {63'd0, iresps[0].ready | iresps[0].last}, 64'd0);
      check("rst_iresp1",     {63'd0, iresps[1].ready | iresps[1].last}, 64'd0);
    end
    check("rst_iresp0_data", iresps[0].data, 64'd0);
    reset = 1'b1;
    set_resp(1'b0, 1'b0, 64'd0);
    step();
    check("post_rst_valid", {63'd0, oreq.valid}, 64'd1);
    check("post_rst_addr",  {32'd0, oreq.addr}, {32'd0, 32'h1000_0040});
    set_resp(1'b1, 1'b1, 64'h0000_0000_1111_2222);
    #1;
    check("post_rst_rdata", iresps[0].data, 64'h0000_0000_1111_2222);
    check("post_rst_other", {63'd0, iresps[1].ready}, 64'd0);
    step();
    check("post_rst_idle",  {63'd0, oreq.valid}, 64'd0);
    ireqs[0] = '0;
    set_resp(1'b0, 1'b0, 64'd0);

    // ---------------- single-owner 4-beat ICache burst ----------------
    step();
    set_req(1, 1'b1, 32'h8000_0000, 8'd3);
    step();
    check("burst_grant_addr", {32'd0, oreq.addr}, {32'd0, 32'h8000_0000});
    check("burst_grant_len",  {56'd0, oreq.len}, 64'd3);
    for (int b = 0; b < 4; b++) begin
      set_resp(1'b1, (b == 3), 64'hCAFE_0000_0000_0000 + 64'(b));
      #1;
      check("burst_data",   iresps[1].data, 64'hCAFE_0000_0000_0000 + 64'(b));
      check("burst_ready1", {63'd0, iresps[1].ready}, 64'd1);
      check("burst_last1",  {63'd0, iresps[1].last}, (b == 3) ? 64'd1 : 64'd0);
      check("burst_ready0", {63'd0, iresps[0].ready}, 64'd0);
      step();
    end
    // The requester is still valid here, so a zero oreq.valid means IDLE.
    check("burst_idle_valid", {63'd0, oreq.valid}, 64'd0);
    check("burst_idle_resp",  {63'd0, iresps[1].ready}, 64'd0);
    ireqs[1] = '0;
    set_resp(1'b0, 1'b0, 64'd0);

    // ---------------- simultaneous requests ----------------
    step();
    set_req(0, 1'b1, 32'h0000_A000, 8'd1);
    set_req(1, 1'b1, 32'h0000_B000, 8'd1);
    step();
    check("simul_first_addr", {32'd0, oreq.addr}, {32'd0, 32'h0000_A000});
    for (int b = 0; b < 2; b++) begin
      set_resp(1'b1, (b == 1), 64'h5500 + 64'(b));
      #1;
      check("simul_d_ready", {63'd0, iresps[0].ready}, 64'd1);
      check("simul_i_ready", {63'd0, iresps[1].ready}, 64'd0);
      step();
    end
    ireqs[0] = '0;
    set_resp(1'b0, 1'b0, 64'd0);
    check("simul_gap", {63'd0, oreq.valid}, 64'd0);
    step();
    check("simul_second_valid", {63'd0, oreq.valid}, 64'd1);
    check("simul_second_addr",  {32'd0, oreq.addr}, {32'd0, 32'h0000_B000});
    for (int b = 0; b < 2; b++) begin
      set_resp(1'b1, (b == 1), 64'h6600 + 64'(b));
      #1;
      check("simul_i_data", iresps[1].data, 64'h6600 + 64'(b));
      step();
    end
    ireqs[1] = '0;
    set_resp(1'b0, 1'b0, 64'd0);

    // ---------------- always-valid single-beat requesters ----------------
    step();
    set_req(0, 1'b1, 32'h0000_0A00, 8'd0);
    set_req(1, 1'b1, 32'h0000_0B00, 8'd0);
    for (int t = 0; t < 4; t++) begin
      step();
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      exp_addr = (t % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00;
`else
      exp_addr = 32'h0000_0A00;
`endif
      check("rr_grant_addr", {32'd0, oreq.addr}, {32'd0, exp_addr});
      set_resp(1'b1, 1'b1, 64'h7700 + 64'(t));
      #1;
      step();
      check("rr_idle", {63'd0, oreq.valid}, 64'd0);
      set_resp(1'b0, 1'b0, 64'd0);
    end
    ireqs[0] = '0;
    ireqs[1] = '0;

    // ---------------- owner drops valid while ICache requests ----------------
    step();
    set_req(0, 1'b1, 32'h0000_C000, 8'd2);
    step();
    set_resp(1'b1, 1'b0, 64'h8800);
    #1;
    check("drop_beat1", {63'd0, iresps[0].ready}, 64'd1);
    step();
    ireqs[0].valid = 1'b0;
    set_req(1, 1'b1, 32'h0000_E000, 8'd0);
    set_resp(1'b0, 1'b0, 64'd0);
    #1;
    check("drop_fwd_valid", {63'd0, oreq.valid}, 64'd0);
    check("drop_fwd_addr",  {32'd0, oreq.addr}, {32'd0, 32'h0000_C000});
    step();
    check("drop_still_owner", {32'd0, oreq.addr}, {32'd0, 32'h0000_C000});
    set_resp(1'b1, 1'b0, 64'h8801);
    #1;
    check("drop_beat2_d", {63'd0, iresps[0].ready}, 64'd1);
    check("drop_beat2_i", {63'd0, iresps[1].ready}, 64'd0);
    step();
    set_resp(1'b1, 1'b1, 64'h8802);
    #1;
    check("drop_last_d", {63'd0, iresps[0].last}, 64'd1);
    check("drop_last_i", {63'd0, iresps[1].ready}, 64'd0);
    step();
    set_resp(1'b0, 1'b0, 64'd0);
    check("drop_idle", {63'd0, oreq.valid}, 64'd0);
    step();
    check("drop_i_grant_valid", {63'd0, oreq.valid}, 64'd1);
    check("drop_i_grant_addr",  {32'd0, oreq.addr}, {32'd0, 32'h0000_E000});
    set_resp(1'b1, 1'b1, 64'h9900);
    #1;
    check("drop_i_data", iresps[1].data, 64'h9900);
    step();
    ireqs[0] = '0;
    ireqs[1] = '0;
    set_resp(1'b0, 1'b0, 64'd0);

    // ---------------- asynchronous reset during beat 2 ----------------
    step();
    set_req(0, 1'b1, 32'h0000_F000, 8'd3);
    step();
    set_resp(1'b1, 1'b0, 64'hAA00);
    step();
    set_resp(1'b1, 1'b0, 64'hAA01);
    #1;
    check("arst_beat2", {63'd0, iresps[0].ready}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_oreq_valid", {63'd0, oreq.valid}, 64'd0);
    check("arst_iresp0",     {63'd0, iresps[0].ready}, 64'd0);
    step();
    check("arst_held_idle", {63'd0, oreq.valid}, 64'd0);
    ireqs[0] = '0;
    set_resp(1'b0, 1'b0, 64'd0);
    reset = 1'b1;
    step();
    check("arst_after_idle", {63'd0, oreq.valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
